// File: rtl/cnoc_axi_mux.sv
// N-to-1 CNOC AXI multiplexer: round-robin AW/AR arbitration, AW-ordered W routing,
// and ID-based B/R return routing. Also carries the CNOC AXI channel type package.

package hydra_axi_pkg;
  localparam int unsigned CnocIdW   = 8;
  localparam int unsigned CnocAddrW = 40;
  localparam int unsigned CnocDataW = 1024;
  localparam int unsigned CnocStrbW = CnocDataW / 8;

  typedef struct packed {
    logic [CnocIdW-1:0]   id;
    logic [CnocAddrW-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } cnoc_ax_s;

  typedef struct packed {
    logic [CnocDataW-1:0] data;
    logic [CnocStrbW-1:0] strb;
    logic                 last;
  } cnoc_w_s;

  typedef struct packed {
    logic [CnocIdW-1:0] id;
    logic [1:0]         resp;
  } cnoc_b_s;

  typedef struct packed {
    logic [CnocIdW-1:0]   id;
    logic [CnocDataW-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } cnoc_r_s;

  typedef struct packed {
    cnoc_ax_s aw;
    logic     aw_valid;
    cnoc_w_s  w;
    logic     w_valid;
    logic     b_ready;
    cnoc_ax_s ar;
    logic     ar_valid;
    logic     r_ready;
  } cnoc_req_s;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    cnoc_b_s b;
    logic    b_valid;
    logic    ar_ready;
    cnoc_r_s r;
    logic    r_valid;
  } cnoc_resp_s;
endpackage

module cnoc_axi_mux
  import hydra_axi_pkg::*;
#(
  parameter int unsigned NUM_MST      = 2,
  parameter int unsigned IDX_W        = $clog2(NUM_MST),
  parameter int unsigned W_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  cnoc_req_s  s_req  [NUM_MST],
  output cnoc_resp_s s_resp [NUM_MST],
  output cnoc_req_s  m_req,
  input  cnoc_resp_s m_resp,
  output logic       err_id
);

  localparam int unsigned PtrW  = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(W_FIFO_DEPTH + 1);
  localparam int unsigned IdTop = CnocIdW - 1;

  typedef logic [IDX_W-1:0] idx_t;

  // First valid requester strictly after ptr, wrapping modulo NUM_MST.
  function automatic idx_t rr_pick(input logic [NUM_MST-1:0] vld, input idx_t ptr);
    idx_t        sel;
    logic        found;
    int unsigned j;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_MST; k++) begin
      j = (32'(ptr) + k) % NUM_MST;
      if (!found && vld[j]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == W_FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [NUM_MST-1:0] aw_vld, ar_vld;
  idx_t aw_ptr_q, aw_ptr_d, aw_sel_q, aw_sel_d, aw_gnt;
  idx_t ar_ptr_q, ar_ptr_d, ar_sel_q, ar_sel_d, ar_gnt;
  logic aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;
  logic m_aw_valid, m_ar_valid, m_w_valid;

  idx_t            w_fifo_q [W_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] w_cnt_q, w_cnt_d;
  idx_t            w_head;
  logic            w_empty, w_full, w_push, w_pop;

  idx_t b_idx, r_idx;
  logic b_bad, r_bad, err_q, err_d;

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      aw_vld[i] = s_req[i].aw_valid;
      ar_vld[i] = s_req[i].ar_valid;
    end
  end

  // A presented-but-unaccepted request keeps its grant until the handshake.
  assign aw_gnt = aw_lock_q ? aw_sel_q : rr_pick(aw_vld, aw_ptr_q);
  assign ar_gnt = ar_lock_q ? ar_sel_q : rr_pick(ar_vld, ar_ptr_q);

  assign w_empty = (w_cnt_q == '0);
  assign w_full  = (w_cnt_q == CntW'(W_FIFO_DEPTH));
  assign w_head  = w_fifo_q[rd_ptr_q];

  assign m_aw_valid = aw_vld[aw_gnt] && !w_full;
  assign m_ar_valid = ar_vld[ar_gnt];
  assign m_w_valid  = !w_empty && s_req[w_head].w_valid;

  assign b_idx = m_resp.b.id[IdTop -: IDX_W];
  assign r_idx = m_resp.r.id[IdTop -: IDX_W];
  assign b_bad = (32'(b_idx) >= NUM_MST);
  assign r_bad = (32'(r_idx) >= NUM_MST);

  always_comb begin
    m_req = '0;
    m_req.aw = s_req[aw_gnt].aw;
    m_req.aw.id[IdTop -: IDX_W] = aw_gnt;
    m_req.aw_valid = m_aw_valid;
    m_req.ar = s_req[ar_gnt].ar;
    m_req.ar.id[IdTop -: IDX_W] = ar_gnt;
    m_req.ar_valid = m_ar_valid;
    m_req.w = s_req[w_head].w;
    m_req.w_valid = m_w_valid;
    // Unroutable responses are swallowed.
    m_req.b_ready = b_bad;
    m_req.r_ready = r_bad;
    for (int i = 0; i < NUM_MST; i++) begin
      s_resp[i] = '0;
      s_resp[i].aw_ready = m_aw_valid && m_resp.aw_ready && (aw_gnt == IDX_W'(i));
      s_resp[i].ar_ready = m_ar_valid && m_resp.ar_ready && (ar_gnt == IDX_W'(i));
      s_resp[i].w_ready  = !w_empty && m_resp.w_ready && (w_head == IDX_W'(i));
      s_resp[i].b = m_resp.b;
      s_resp[i].b.id[IdTop -: IDX_W] = '0;
      s_resp[i].b_valid = m_resp.b_valid && (b_idx == IDX_W'(i));
      s_resp[i].r = m_resp.r;
      s_resp[i].r.id[IdTop -: IDX_W] = '0;
      s_resp[i].r_valid = m_resp.r_valid && (r_idx == IDX_W'(i));
      if (b_idx == IDX_W'(i)) m_req.b_ready = s_req[i].b_ready;
      if (r_idx == IDX_W'(i)) m_req.r_ready = s_req[i].r_ready;
    end
  end

  always_comb begin
    aw_lock_d = aw_lock_q;
    aw_sel_d  = aw_sel_q;
    aw_ptr_d  = aw_ptr_q;
    ar_lock_d = ar_lock_q;
    ar_sel_d  = ar_sel_q;
    ar_ptr_d  = ar_ptr_q;
    if (m_aw_valid) begin
      if (m_resp.aw_ready) begin
        aw_lock_d = 1'b0;
        aw_ptr_d  = aw_gnt;
      end else begin
        aw_lock_d = 1'b1;
        aw_sel_d  = aw_gnt;
      end
    end
    if (m_ar_valid) begin
      if (m_resp.ar_ready) begin
        ar_lock_d = 1'b0;
        ar_ptr_d  = ar_gnt;
      end else begin
        ar_lock_d = 1'b1;
        ar_sel_d  = ar_gnt;
      end
    end

    w_push   = m_aw_valid && m_resp.aw_ready;
    w_pop    = m_w_valid && m_resp.w_ready && s_req[w_head].w.last;
    wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    w_cnt_d  = w_cnt_q;
    if (w_push && !w_pop) w_cnt_d = w_cnt_q + 1'b1;
    if (!w_push && w_pop) w_cnt_d = w_cnt_q - 1'b1;

    err_d = err_q | (m_resp.b_valid && b_bad) | (m_resp.r_valid && r_bad);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      aw_ptr_q  <= idx_t'(NUM_MST - 1);
      ar_ptr_q  <= idx_t'(NUM_MST - 1);
      aw_sel_q  <= '0;
      ar_sel_q  <= '0;
      aw_lock_q <= 1'b0;
      ar_lock_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      w_cnt_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < W_FIFO_DEPTH; i++) w_fifo_q[i] <= '0;
    end else begin
      aw_ptr_q  <= aw_ptr_d;
      ar_ptr_q  <= ar_ptr_d;
      aw_sel_q  <= aw_sel_d;
      ar_sel_q  <= ar_sel_d;
      aw_lock_q <= aw_lock_d;
      ar_lock_q <= ar_lock_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      w_cnt_q   <= w_cnt_d;
      err_q     <= err_d;
      if (w_push) w_fifo_q[wr_ptr_q] <= aw_gnt;
    end
  end

  assign err_id = err_q;

endmodule

// File: tb/tb_cnoc_axi_mux.sv
// Self-checking bench for cnoc_axi_mux (3 requesters): directed scenarios followed by
// randomized AR/R traffic compared against a round-robin reference model.

module tb_cnoc_axi_mux;
  import hydra_axi_pkg::*;

  localparam int NMst = 3;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  cnoc_req_s  s_req  [NMst];
  cnoc_resp_s s_resp [NMst];
  cnoc_req_s  m_req;
  cnoc_resp_s m_resp;
  logic       err_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnoc_axi_mux #(
    .NUM_MST     (NMst),
    .W_FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .s_req (s_req),
    .s_resp(s_resp),
    .m_req (m_req),
    .m_resp(m_resp),
    .err_id(err_id)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Reference round-robin: first valid index after 'last', modulo NMst; -1 if none.
  function automatic int rr_next(input logic [NMst-1:0] vld, input int last);
    int r;
    r = -1;
    for (int k = 1; k <= NMst; k++) begin
      if (r < 0 && vld[(last + k) % NMst]) r = (last + k) % NMst;
    end
    return r;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < NMst; i++) s_req[i] = '0;
    m_resp = '0;
  endtask

  task automatic do_reset();
    idle_all();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  logic [NMst-1:0] pend;
  logic [39:0]     addr_m [NMst];
  logic [5:0]      idl_m  [NMst];
  int              last_ar, owner, sel, ridx;
  logic            ar_rdy, r_v, err_exp, r_rdy_exp;
  logic [5:0]      rlow;

  initial begin
    idle_all();
    // Reset state
    @(negedge clk);
    #1;
    check_eq("rst_err_id", err_id, 1'b0);
    check_eq("rst_aw_valid", m_req.aw_valid, 1'b0);
    check_eq("rst_ar_valid", m_req.ar_valid, 1'b0);
    check_eq("rst_w_valid", m_req.w_valid, 1'b0);
    for (int i = 0; i < NMst; i++) begin
      check_eq("rst_aw_ready", s_resp[i].aw_ready, 1'b0);
      check_eq("rst_b_valid", s_resp[i].b_valid, 1'b0);
    end
    do_reset();

    // Empty W FIFO blocks W even with a requester offering data
    s_req[0].w_valid = 1'b1;
    s_req[0].w.last  = 1'b1;
    m_resp.w_ready   = 1'b1;
    #1;
    check_eq("empty_w_valid", m_req.w_valid, 1'b0);
    check_eq("empty_w_ready", s_resp[0].w_ready, 1'b0);
    idle_all();

    // Single write from master 1: ID tagging and B return
    s_req[1].aw_valid = 1'b1;
    s_req[1].aw.addr  = 40'h100;
    s_req[1].aw.id    = 8'h03;
    m_resp.aw_ready   = 1'b1;
    #1;
    check_eq("t1_aw_valid", m_req.aw_valid, 1'b1);
    check_eq("t1_aw_id", m_req.aw.id, 8'h43);
    check_eq("t1_aw_addr", m_req.aw.addr, 40'h100);
    check_eq("t1_aw_ready1", s_resp[1].aw_ready, 1'b1);
    check_eq("t1_aw_ready0", s_resp[0].aw_ready, 1'b0);
    @(negedge clk);
    s_req[1].aw_valid = 1'b0;
    s_req[1].w_valid  = 1'b1;
    s_req[1].w.last   = 1'b1;
    s_req[1].w.data   = CnocDataW'(64'hDEAD_0001);
    m_resp.w_ready    = 1'b1;
    #1;
    check_eq("t1_w_valid", m_req.w_valid, 1'b1);
    check_eq("t1_w_data", m_req.w.data[63:0], 64'hDEAD_0001);
    check_eq("t1_w_ready1", s_resp[1].w_ready, 1'b1);
    check_eq("t1_w_ready0", s_resp[0].w_ready, 1'b0);
    @(negedge clk);
    s_req[1].w_valid  = 1'b0;
    s_req[1].b_ready  = 1'b1;
    m_resp.b_valid    = 1'b1;
    m_resp.b.id       = 8'h43;
    #1;
    check_eq("t1_b_valid1", s_resp[1].b_valid, 1'b1);
    check_eq("t1_b_id", s_resp[1].b.id, 8'h03);
    check_eq("t1_b_valid0", s_resp[0].b_valid, 1'b0);
    check_eq("t1_b_ready", m_req.b_ready, 1'b1);
    check_eq("t1_w_idle", m_req.w_valid, 1'b0);
    do_reset();

    // Alternating AW grants, then FIFO-full backpressure and release
    s_req[0].aw_valid = 1'b1;
    s_req[0].aw.id    = 8'h11;
    s_req[1].aw_valid = 1'b1;
    s_req[1].aw.id    = 8'h22;
    m_resp.aw_ready   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("t2_aw_gnt", m_req.aw.id[7:6], 2'(c % 2));
      check_eq("t2_aw_ready", s_resp[c % 2].aw_ready, 1'b1);
      check_eq("t2_aw_ready_other", s_resp[1 - (c % 2)].aw_ready, 1'b0);
      @(negedge clk);
    end
    s_req[0].w_valid = 1'b1;
    s_req[0].w.last  = 1'b1;
    m_resp.w_ready   = 1'b1;
    #1;
    check_eq("t2_full_aw_valid", m_req.aw_valid, 1'b0);
    check_eq("t2_full_aw_ready0", s_resp[0].aw_ready, 1'b0);
    check_eq("t2_full_aw_ready1", s_resp[1].aw_ready, 1'b0);
    check_eq("t2_head_w_ready0", s_resp[0].w_ready, 1'b1);
    check_eq("t2_head_w_ready1", s_resp[1].w_ready, 1'b0);
    @(negedge clk);
    s_req[0].w_valid = 1'b0;
    #1;
    check_eq("t2_reopen_aw_valid", m_req.aw_valid, 1'b1);
    check_eq("t2_reopen_gnt", m_req.aw.id[7:6], 2'd0);
    check_eq("t2_reopen_aw_ready0", s_resp[0].aw_ready, 1'b1);
    do_reset();

    // W ordering: master 1's early W waits behind master 0's 4-beat burst
    m_resp.aw_ready   = 1'b1;
    m_resp.w_ready    = 1'b1;
    s_req[0].aw_valid = 1'b1;
    s_req[0].aw.len   = 8'd3;
    #1;
    check_eq("t3_aw0_gnt", m_req.aw.id[7:6], 2'd0);
    @(negedge clk);
    s_req[0].aw_valid = 1'b0;
    s_req[1].aw_valid = 1'b1;
    s_req[1].w_valid  = 1'b1;
    s_req[1].w.last   = 1'b1;
    s_req[1].w.data   = CnocDataW'(64'hB1B1);
    s_req[0].w_valid  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_req[0].w.data = CnocDataW'(64'hA000 + b);
      s_req[0].w.last = (b == 3);
      #1;
      if (b == 0) check_eq("t3_aw1_gnt", m_req.aw.id[7:6], 2'd1);
      check_eq("t3_w_ready1_blocked", s_resp[1].w_ready, 1'b0);
      check_eq("t3_w_ready0", s_resp[0].w_ready, 1'b1);
      check_eq("t3_w_data0", m_req.w.data[63:0], 64'hA000 + 64'(b));
      @(negedge clk);
      s_req[1].aw_valid = 1'b0;
    end
    s_req[0].w_valid = 1'b0;
    #1;
    check_eq("t3_w_ready1", s_resp[1].w_ready, 1'b1);
    check_eq("t3_w_valid1", m_req.w_valid, 1'b1);
    check_eq("t3_w_data1", m_req.w.data[63:0], 64'hB1B1);
    do_reset();

    // AR grant lock while slave stalls, then round-robin to master 0
    s_req[1].ar_valid = 1'b1;
    s_req[1].ar.addr  = 40'h55_0000;
    s_req[1].ar.id    = 8'h07;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin
        s_req[0].ar_valid = 1'b1;
        s_req[0].ar.addr  = 40'h66_0000;
      end
      #1;
      check_eq("t5_ar_gnt_locked", m_req.ar.id, 8'h47);
      check_eq("t5_ar_addr_stable", m_req.ar.addr, 40'h55_0000);
      check_eq("t5_ar_ready0", s_resp[0].ar_ready, 1'b0);
      @(negedge clk);
    end
    m_resp.ar_ready = 1'b1;
    #1;
    check_eq("t5_ar_ready1_hs", s_resp[1].ar_ready, 1'b1);
    check_eq("t5_ar_hs_gnt", m_req.ar.id[7:6], 2'd1);
    @(negedge clk);
    #1;
    check_eq("t5_ar_next_gnt", m_req.ar.id[7:6], 2'd0);
    check_eq("t5_ar_next_addr", m_req.ar.addr, 40'h66_0000);
    check_eq("t5_ar_next_ready0", s_resp[0].ar_ready, 1'b1);
    do_reset();

    // Bad response index 3 with 3 requesters: dropped, sticky error
    m_resp.b_valid = 1'b1;
    m_resp.b.id    = 8'hC5;
    #1;
    check_eq("t6_bad_b_ready", m_req.b_ready, 1'b1);
    for (int i = 0; i < NMst; i++) check_eq("t6_bad_b_valid", s_resp[i].b_valid, 1'b0);
    check_eq("t6_err_before", err_id, 1'b0);
    @(posedge clk);
    #1;
    check_eq("t6_err_set", err_id, 1'b1);
    @(negedge clk);
    m_resp.b_valid    = 1'b0;
    m_resp.r_valid    = 1'b1;
    m_resp.r.id       = 8'h89;
    s_req[2].r_ready  = 1'b1;
    #1;
    check_eq("t6_r_valid2", s_resp[2].r_valid, 1'b1);
    check_eq("t6_r_id2", s_resp[2].r.id, 8'h09);
    check_eq("t6_r_valid0", s_resp[0].r_valid, 1'b0);
    check_eq("t6_r_ready", m_req.r_ready, 1'b1);
    s_req[2].r_ready = 1'b0;
    #1;
    check_eq("t6_r_ready_follow", m_req.r_ready, 1'b0);
    m_resp.r_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("t6_err_sticky", err_id, 1'b1);
    end
    arst_n = 1'b0;
    #1;
    check_eq("t6_err_cleared", err_id, 1'b0);
    do_reset();

    // Randomized AR arbitration and R routing against the reference model
    pend    = '0;
    last_ar = NMst - 1;
    owner   = -1;
    err_exp = 1'b0;
    for (int i = 0; i < NMst; i++) begin
      addr_m[i] = '0;
      idl_m[i]  = '0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NMst; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]   = 1'b1;
          addr_m[i] = 40'($urandom);
          idl_m[i]  = 6'($urandom);
        end
        s_req[i].ar_valid = pend[i];
        s_req[i].ar.addr  = addr_m[i];
        s_req[i].ar.id    = {2'b00, idl_m[i]};
        s_req[i].r_ready  = 1'($urandom);
      end
      ar_rdy          = 1'($urandom);
      m_resp.ar_ready = ar_rdy;
      ridx            = int'($urandom_range(3, 0));
      rlow            = 6'($urandom);
      r_v             = 1'($urandom);
      m_resp.r_valid  = r_v;
      m_resp.r.id     = {2'(ridx), rlow};
      #1;
      sel = (owner >= 0) ? owner : rr_next(pend, last_ar);
      check_eq("rnd_ar_valid", m_req.ar_valid, pend != '0);
      if (sel >= 0) begin
        check_eq("rnd_ar_addr", m_req.ar.addr, addr_m[sel]);
        check_eq("rnd_ar_id", m_req.ar.id, {2'(sel), idl_m[sel]});
      end
      for (int i = 0; i < NMst; i++) begin
        check_eq("rnd_ar_ready", s_resp[i].ar_ready, (i == sel) && ar_rdy);
        check_eq("rnd_r_valid", s_resp[i].r_valid, r_v && (ridx == i));
      end
      if (ridx < NMst) begin
        r_rdy_exp = s_req[ridx].r_ready;
        check_eq("rnd_r_id", s_resp[ridx].r.id, {2'b00, rlow});
      end else begin
        r_rdy_exp = 1'b1;
      end
      check_eq("rnd_r_ready", m_req.r_ready, r_rdy_exp);
      if (r_v && ridx == NMst) err_exp = 1'b1;
      @(posedge clk);
      #1;
      if (sel >= 0) begin
        if (ar_rdy) begin
          pend[sel] = 1'b0;
          last_ar   = sel;
          owner     = -1;
        end else begin
          owner = sel;
        end
      end
      check_eq("rnd_err_id", err_id, err_exp);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnoc_axi_mux.md
Name: cnoc_axi_mux

Overview:
- N-to-1 AXI multiplexer that shares a single CNOC AXI slave port (1024-bit data, hydra_axi_pkg cnoc_req_s/cnoc_resp_s) between NUM_MST requesters, e.g. the bus-functional master plus a DMA engine.
- Arbitrates AW and AR independently with round-robin, keeps W beats in AW-grant order, and routes B/R responses back using master-index bits carried in the AXI ID.

Parameters:
- NUM_MST, 2, number of requester ports (2..8).
- IDX_W, $clog2(NUM_MST), master-index bits placed in the ID MSBs.
- W_FIFO_DEPTH, 4, depth of the W-order FIFO, which is also the maximum number of accepted AWs with W data not yet complete.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- s_req  in  NUM_MST x cnoc_req_s  requester-side AXI requests.
- s_resp  out  NUM_MST x cnoc_resp_s  requester-side AXI responses/readies.
- m_req  out  cnoc_req_s  slave-side AXI request.
- m_resp  in  cnoc_resp_s  slave-side AXI response/readies.
- err_id  out  1  sticky flag: response carried an index >= NUM_MST.

Behaviour:
- Reset state:
  - All s_resp valids/readies, m_req valids and err_id are 0.
  - W FIFO is empty.
  - Both RR pointers = NUM_MST-1, so master 0 wins first.
- Reset mid-operation discards all in-flight state. Requesters and slave are reset together with this block.
- ID rule:
  - Requesters drive the top IDX_W ID bits as 0.
  - On AW/AR forwarding, the mux overwrites those bits with the requester index.
  - On B/R return, it clears those bits.
- AW path, zero-latency (combinational valid/ready forwarding):
  - Grant = first aw_valid requester scanning from pointer+1 modulo NUM_MST.
  - Once m_req.aw_valid is asserted, the grant is locked until the m_resp.aw_ready handshake. Payload and valid stay stable per AXI even if a higher-priority requester arrives.
  - On handshake, the pointer moves to the granted index and the index is pushed into the W FIFO.
  - When the FIFO is full: m_req.aw_valid = 0 and all s_resp aw_ready = 0.
  - Only the granted requester sees aw_ready.
- AR path: same RR arbitration and locking, with its own pointer and no FIFO.
- W path:
  - The FIFO head selects which requester's W channel is muxed to m_req; only that requester gets w_ready = m_resp.w_ready.
  - FIFO empty: m_req.w_valid = 0 and all w_ready = 0.
  - Pop on the W handshake with w.last = 1. The next head is usable in the following cycle.
  - An AW push and a last-beat pop in the same cycle are both performed; the count is unchanged. A push while full is impossible because AW is blocked.
  - W data may precede its AW only if that requester is already the head. Otherwise it waits.
- B path:
  - idx = top IDX_W bits of m_resp.b.id.
  - s_resp[idx].b_valid = m_resp.b_valid; m_req.b_ready = s_resp-side b_ready of idx.
  - The other requesters see b_valid = 0.
- R path: same as B using r.id. Routing is held across beats until the r.last handshake; per-beat ID decode is also acceptable because ID is stable within a burst.
- Bad index (idx >= NUM_MST, only when NUM_MST is not a power of 2):
  - ready is forced to 1, so the response is consumed and dropped.
  - err_id is set and held until reset.
- Arbitration pointers advance only on a completed handshake, never on valid alone.
- No combinational ready->valid loops: valid outputs never depend on the corresponding ready.

Test Plan:
- Master 1 issues AW addr 'h100 id 3 len 0, then one W beat. Required:
  - m_req.aw.id has top bits = 1, low bits = 3.
  - Slave B with that ID produces s_resp[1].b_valid with id 3.
  - s_resp[0] stays idle.
- Both masters hold aw_valid continuously with aw_ready = 1. Required: grants alternate 0,1,0,1 over 4 cycles, starting with 0 after reset.
- Master 0 sends AW len 3, then master 1 sends AW len 0; master 1 presents W first. Required:
  - Master 1 w_ready stays 0 until master 0's 4 beats complete with last.
  - Master 1's beat is forwarded in the next cycle.
- 4 AWs accepted with slave w_ready = 0. Required:
  - The 5th AW sees aw_ready = 0 and m_req.aw_valid = 0.
  - Completing one W burst re-enables acceptance the next cycle.
- Master 1's AR is pending with slave ar_ready = 0 for 5 cycles, then master 0 raises ar_valid. Required:
  - m_req.ar payload and grant to master 1 are unchanged until the handshake.
  - Master 0 wins next.
- NUM_MST = 3; slave returns B with index 3. Required:
  - b_ready = 1 and no s_resp b_valid.
  - err_id = 1 and stays 1 until arst_n is asserted.
